mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: LEN, default 32, data/word width; ADDR_WIDTH, default 17, RAM address width.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 rdy_in  input  1  global ready; low = stall, all registers hold.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller idle, request accepted this edge if req_valid.
REQ-007 req_pc_flag  input  1  1 = instruction fetch, 0 = data access.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-011 req_addr  input  ADDR_WIDTH  start byte address.
REQ-012 req_wdata  input  LEN  store data, low bytes used.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_pc_flag  output  1  req_pc_flag of completed request.
REQ-015 resp_data  output  LEN  extended load data; 0 for stores.
REQ-016 mem_a  output  ADDR_WIDTH  byte RAM address.
REQ-017 mem_dout  output  8  byte to RAM.
REQ-018 mem_wr  output  1  RAM write enable.
REQ-019 mem_din  input  8  byte from RAM; valid one cycle after mem_a presented.

Function
REQ-020 States IDLE, READ, WRITE; req_ready = 1 only in IDLE.
REQ-021 Acceptance: IDLE and req_valid and rdy_in at edge E0 -> latch all req_* fields; N = 1/2/4 bytes from req_size; go READ (req_we=0) or WRITE (req_we=1).
REQ-022 req_valid while not IDLE ignored; no queueing.
REQ-023 READ: cycle after E(k) drives mem_a = addr+k for k = 0..N-1, mem_wr=0; byte k captured from mem_din at edge E(k+2).
REQ-024 READ completion: last byte captured at E(N+1); resp_valid=1, state IDLE in cycle after E(N+1); word load latency 5 cycles, byte 2 cycles.
REQ-025 Assembly little-endian: byte k -> resp_data[8k+7:8k]; upper bits sign-extended from bit 8N-1 if req_signed, else zero; fetches always full word.
REQ-026 WRITE: cycle after E(k) drives mem_wr=1, mem_a=addr+k, mem_dout=wdata[8k+7:8k], k = 0..N-1.
REQ-027 WRITE completion: cycle after E(N) mem_wr=0, resp_valid=1, resp_data=0, state IDLE; word store latency 4 cycles.
REQ-028 Address increment modulo 2^ADDR_WIDTH (0x1FFFF+1 -> 0x00000); misaligned addresses permitted.
REQ-029 resp_valid high exactly one cycle; resp_data, resp_pc_flag hold last value until next completion.
REQ-030 New request accepted in the same cycle resp_valid is high (back-to-back, no bubble).
REQ-031 rdy_in low: state, byte counter, capture registers hold; mem_wr forced 0; mem_a held so RAM re-reads same byte; resume continues without loss or duplicate write.
REQ-032 In IDLE mem_wr=0, mem_a holds last value, mem_dout=0.

Reset
REQ-033 rst_in high at edge: state IDLE, resp_valid=0, resp_data=0, resp_pc_flag=0, mem_wr=0, mem_a=0, mem_dout=0, counters 0.
REQ-034 Reset mid-operation aborts: remaining bytes not written, no resp_valid for aborted request.
REQ-035 rst_in has priority over rdy_in.

Verification
REQ-036 Word fetch addr 0x00100, RAM bytes 13 05 00 00 -> resp_valid 5 cycles after acceptance, resp_data=0x00000513, resp_pc_flag=1.
REQ-037 Signed byte load addr 0x00200 holding 0x80 -> resp_data=0xFFFFFF80; unsigned -> 0x00000080; latency 2.
REQ-038 Word store 0xDEADBEEF at 0x1FFFE -> writes EF@0x1FFFE, BE@0x1FFFF, AD@0x00000, DE@0x00001, mem_wr 4 cycles, resp_valid cycle 5.
REQ-039 rdy_in low 3 cycles in middle of word load -> same resp_data as unstalled run, latency +3, no mem_wr.
REQ-040 rst_in after 2nd byte of word store -> mem_wr=0 next cycle, bytes 2-3 unchanged in RAM, no resp_valid, req_ready=1.
REQ-041 Back-to-back: new req_valid held high during resp_valid cycle -> accepted that edge, no idle cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns byte/half/word load and store
// requests into a sequence of single-byte RAM accesses. Loads are assembled
// little-endian and extended. Stores drive one byte per cycle.
module mem_ctrl #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_pc_flag,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN-1:0]        req_wdata,
    output logic                  resp_valid,
    output logic                  resp_pc_flag,
    output logic [LEN-1:0]        resp_data,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q,     state_d;
    logic [2:0]            step_q,      step_d;
    logic [2:0]            nBytes_q,    nBytes_d;
    logic                  sext_q,      sext_d;
    logic                  pcFlag_q,    pcFlag_d;
    logic [LEN-1:0]        wdata_q,     wdata_d;
    logic [LEN-1:0]        capBuf_q,    capBuf_d;
    logic [ADDR_WIDTH-1:0] memA_q,      memA_d;
    logic [7:0]            memDout_q,   memDout_d;
    logic                  memWr_q,     memWr_d;
    logic                  respValid_q, respValid_d;
    logic                  respPc_q,    respPc_d;
    logic [LEN-1:0]        respData_q,  respData_d;

    // The RAM keeps sampling the held address while stalled, so the byte that
    // was in flight on the first stalled edge is parked here until resume.
    logic [7:0]            pend_q;
    logic                  pendVld_q;

    logic [7:0]            inByte;
    logic [2:0]            stepNext;
    logic [2:0]            stepPrev;
    logic [1:0]            capIdx;
    logic [1:0]            wrIdx;
    logic [LEN-1:0]        ext;

    // Next-state and datapath update for one active (non-stalled) edge.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        nBytes_d    = nBytes_q;
        sext_d      = sext_q;
        pcFlag_d    = pcFlag_q;
        wdata_d     = wdata_q;
        capBuf_d    = capBuf_q;
        memA_d      = memA_q;
        memDout_d   = memDout_q;
        memWr_d     = memWr_q;
        respValid_d = 1'b0;
        respPc_d    = respPc_q;
        respData_d  = respData_q;
        inByte      = pendVld_q ? pend_q : mem_din;
        stepNext    = step_q + 3'd1;
        stepPrev    = step_q - 3'd1;
        capIdx      = stepPrev[1:0];
        wrIdx       = stepNext[1:0];
        ext         = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pcFlag_d = req_pc_flag;
                    sext_d   = req_signed;
                    wdata_d  = req_wdata;
                    capBuf_d = '0;
                    step_d   = 3'd0;
                    memA_d   = req_addr;
                    if (req_pc_flag || req_size[1]) begin
                        nBytes_d = 3'd4;
                    end else if (req_size[0]) begin
                        nBytes_d = 3'd2;
                    end else begin
                        nBytes_d = 3'd1;
                    end
                    if (req_we) begin
                        state_d   = WRITE;
                        memDout_d = req_wdata[7:0];
                        memWr_d   = 1'b1;
                    end else begin
                        state_d   = READ;
                        memDout_d = 8'd0;
                        memWr_d   = 1'b0;
                    end
                end
            end

            READ: begin
                if (step_q != 3'd0) begin
                    capBuf_d[{capIdx, 3'b000} +: 8] = inByte;
                end
                if (step_q == nBytes_q) begin
                    case (nBytes_q)
                        3'd1: ext = sext_q ? {{(LEN-8){capBuf_d[7]}}, capBuf_d[7:0]}
                                           : {{(LEN-8){1'b0}}, capBuf_d[7:0]};
                        3'd2: ext = sext_q ? {{(LEN-16){capBuf_d[15]}}, capBuf_d[15:0]}
                                           : {{(LEN-16){1'b0}}, capBuf_d[15:0]};
                        default: ext = capBuf_d;
                    endcase
                    respValid_d = 1'b1;
                    respData_d  = ext;
                    respPc_d    = pcFlag_q;
                    state_d     = IDLE;
                    step_d      = 3'd0;
                end else begin
                    step_d = stepNext;
                    if (stepNext < nBytes_q) begin
                        memA_d = memA_q + ADDR_ONE;
                    end
                end
            end

            WRITE: begin
                if (stepNext == nBytes_q) begin
                    memWr_d     = 1'b0;
                    memDout_d   = 8'd0;
                    respValid_d = 1'b1;
                    respData_d  = '0;
                    respPc_d    = pcFlag_q;
                    state_d     = IDLE;
                    step_d      = 3'd0;
                end else begin
                    step_d    = stepNext;
                    memA_d    = memA_q + ADDR_ONE;
                    memDout_d = wdata_q[{wrIdx, 3'b000} +: 8];
                end
            end

            default: begin
                state_d = IDLE;
                memWr_d = 1'b0;
            end
        endcase
    end

    // State registers: reset wins, stall holds everything except the parked byte.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            nBytes_q    <= 3'd0;
            sext_q      <= 1'b0;
            pcFlag_q    <= 1'b0;
            wdata_q     <= '0;
            capBuf_q    <= '0;
            memA_q      <= '0;
            memDout_q   <= 8'd0;
            memWr_q     <= 1'b0;
            respValid_q <= 1'b0;
            respPc_q    <= 1'b0;
            respData_q  <= '0;
            pend_q      <= 8'd0;
            pendVld_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            step_q      <= step_d;
            nBytes_q    <= nBytes_d;
            sext_q      <= sext_d;
            pcFlag_q    <= pcFlag_d;
            wdata_q     <= wdata_d;
            capBuf_q    <= capBuf_d;
            memA_q      <= memA_d;
            memDout_q   <= memDout_d;
            memWr_q     <= memWr_d;
            respValid_q <= respValid_d;
            respPc_q    <= respPc_d;
            respData_q  <= respData_d;
            pendVld_q   <= 1'b0;
        end else if (state_q == READ && !pendVld_q) begin
            pend_q    <= mem_din;
            pendVld_q <= 1'b1;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = respValid_q;
    assign resp_pc_flag = respPc_q;
    assign resp_data    = respData_q;
    assign mem_a        = memA_q;
    assign mem_dout     = memDout_q;
    assign mem_wr       = memWr_q & rdy_in;

endmodule
